// File: rtl/uart_wb_bridge_pkg.sv
// Shared definitions for the UART-to-Wishbone bridge: command bytes and FSM states.
package uart_wb_bridge_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
    WB_WRITE,
    WB_READ,
    TX_DATA
  } state_t;

endpackage

// File: rtl/uart_byte_io.sv
// 8N1 byte transceiver: synchronized mid-bit RX sampler and back-to-back TX serializer,
// both timed by the same CLKS_PER_BIT bit-period counter rule.
module uart_byte_io #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Bit-period counter rule shared by both directions: wraps at lim.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] lim);
    return (cnt == lim) ? '0 : cnt + 1'b1;
  endfunction

  logic             rx_s1, rx_s2, rx_s3;
  logic             rx_fall;
  logic             rx_active;
  logic [3:0]       rx_idx;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] rx_lim;
  logic             rx_tick;
  logic [7:0]       rx_shift;

  logic             tx_active;
  logic [3:0]       tx_idx;
  logic [CNT_W-1:0] tx_cnt;
  logic [8:0]       tx_shift;
  logic             tx_line;
  logic             tx_tick;
  logic             tx_last;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;
  // Index 0 is the start bit, checked half a bit in; later bits are a full bit apart.
  assign rx_lim  = (rx_idx == 4'd0) ? HALF_LIM : FULL_LIM;
  assign rx_tick = rx_active && (rx_cnt == rx_lim);

  // Receive sampler: start re-check, 8 data bits LSB first, stop-bit validation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_idx    <= '0;
      rx_cnt    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_active) begin
        rx_cnt <= '0;
        rx_idx <= '0;
        if (rx_fall) rx_active <= 1'b1;
      end else begin
        rx_cnt <= cnt_next(rx_cnt, rx_lim);
        if (rx_tick) begin
          if (rx_idx == 4'd0) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (rx_s2) rx_active <= 1'b0;
            else       rx_idx    <= 4'd1;
          end else if (rx_idx <= 4'd8) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
          end else begin
            // Framing error (stop low) or disabled receiver drops the byte.
            rx_active <= 1'b0;
            rx_valid  <= rx_s2 & rx_en;
          end
        end
      end
    end
  end

  assign rx_data = rx_shift;

  assign tx_tick  = tx_active && (tx_cnt == FULL_LIM);
  assign tx_last  = tx_tick && (tx_idx == 4'd9);
  // Ready during the final clock of a stop bit so the next byte follows without a gap.
  assign tx_ready = !tx_active || tx_last;
  assign tx_busy  = tx_active;

  // Transmit serializer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_active <= 1'b0;
      tx_idx    <= '0;
      tx_cnt    <= '0;
      tx_shift  <= '1;
      tx_line   <= 1'b1;
    end else if (tx_start && tx_ready) begin
      tx_active <= 1'b1;
      tx_idx    <= '0;
      tx_cnt    <= '0;
      tx_shift  <= {1'b1, tx_data};
      tx_line   <= 1'b0;
    end else if (tx_last) begin
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_line   <= 1'b1;
    end else if (tx_active) begin
      tx_cnt <= cnt_next(tx_cnt, FULL_LIM);
      if (tx_tick) begin
        tx_line  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_idx   <= tx_idx + 1'b1;
      end
    end
  end

  assign uart_tx = tx_line;

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone master: decodes read/write command frames from the serial line,
// runs one classic Wishbone cycle per command and returns read data over UART.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  input  logic                  start_rx,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int ADDR_BYTES   = ADDR_WIDTH / 8;
  localparam int DATA_BYTES   = DATA_WIDTH / 8;

  state_t                state, next_state;
  logic                  is_write;
  logic [7:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  tx_start;
  logic                  tx_ready;
  logic                  tx_busy;
  logic                  addr_last;
  logic                  data_last;
  logic                  tx_all_sent;

  uart_byte_io #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_io (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .rx_en   (start_rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (rd_word[7:0]),
    .tx_start(tx_start),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .uart_tx (uart_tx)
  );

  assign addr_last   = (byte_cnt == 8'(ADDR_BYTES - 1));
  assign data_last   = (byte_cnt == 8'(DATA_BYTES - 1));
  assign tx_all_sent = (byte_cnt == 8'(DATA_BYTES));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; bytes arriving in the bus and reply states are ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) next_state = RX_ADDR;
      RX_ADDR:  if (rx_valid && addr_last) next_state = is_write ? RX_DATA : WB_READ;
      RX_DATA:  if (rx_valid && data_last) next_state = WB_WRITE;
      WB_WRITE: if (wb_ack_i) next_state = IDLE;
      WB_READ:  if (wb_ack_i) next_state = TX_DATA;
      TX_DATA:  if (tx_all_sent && !tx_busy) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Bus strobes and TX byte requests decoded from the current state.
  always_comb begin
    wb_cyc_o = (state == WB_WRITE) || (state == WB_READ);
    wb_stb_o = (state == WB_WRITE) || (state == WB_READ);
    wb_we_o  = (state == WB_WRITE);
    tx_start = (state == TX_DATA) && tx_ready && !tx_all_sent;
  end

  // Field assembly (LSB-first shift-in), read-data capture and reply byte shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_write <= 1'b0;
      byte_cnt <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      rd_word  <= '0;
    end else begin
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (rx_valid) is_write <= (rx_data == CMD_WRITE);
        end
        RX_ADDR: if (rx_valid) begin
          adr_q    <= ADDR_WIDTH'({rx_data, adr_q} >> 8);
          byte_cnt <= addr_last ? '0 : byte_cnt + 1'b1;
        end
        RX_DATA: if (rx_valid) begin
          dat_q    <= DATA_WIDTH'({rx_data, dat_q} >> 8);
          byte_cnt <= data_last ? '0 : byte_cnt + 1'b1;
        end
        WB_READ: if (wb_ack_i) begin
          rd_word  <= wb_dat_i;
          byte_cnt <= '0;
        end
        TX_DATA: if (tx_start) begin
          rd_word  <= rd_word >> 8;
          byte_cnt <= byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: stimulus pushes expected bus cycles and reply
// bytes; independent monitors pop and compare as the DUT produces them.
module tb_uart_wb_bridge;
  import uart_wb_bridge_pkg::*;

  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        uart_tx;
  logic        start_rx;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  uart_wb_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .BAUD_RATE (BAUD_RATE),
    .CLOCK_FREQ(CLOCK_FREQ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .start_rx(start_rx),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o (wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
  } wb_exp_t;

  wb_exp_t     exp_wb[$];
  logic [7:0]  exp_tx[$];
  int          total = 0;
  int          bad   = 0;
  int          ack_delay = 0;
  int          ack_wait  = 0;
  logic [31:0] rd_value  = 32'h0;
  bit          tx_abort  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Wishbone slave: ack after ack_delay waiting clocks, for one clock, with rd_value.
  always @(posedge clk) begin
    #1;
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
    end else if (!rst && wb_cyc_o && wb_stb_o) begin
      if (ack_wait >= ack_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = rd_value;
        ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end
  end

  // Bus monitor: stability while the cycle is open, scoreboard compare at ack.
  logic    in_cyc = 1'b0;
  logic [49:0] snap;
  wb_exp_t e;
  always @(negedge clk) begin
    if (!rst && wb_cyc_o) begin
      if (!in_cyc) begin
        in_cyc = 1'b1;
        snap   = {wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o};
      end else begin
        check("wb_hold_stable", {wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, snap);
      end
      if (wb_ack_i) begin
        check("wb_cycle_expected", exp_wb.size() > 0, 1);
        if (exp_wb.size() > 0) begin
          e = exp_wb.pop_front();
          check("wb_cycle", {wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, e.we, e.adr, e.dat});
        end
      end
    end else begin
      in_cyc = 1'b0;
    end
  end

  // UART TX monitor: decode 8N1 at mid-bit from the falling start edge.
  logic [7:0] mon_b;
  logic       mon_st, mon_sp;
  initial begin
    forever begin
      @(negedge uart_tx);
      repeat (CPB / 2) @(posedge clk);
      #1 mon_st = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 mon_b[i] = uart_tx;
      end
      repeat (CPB) @(posedge clk);
      #1 mon_sp = uart_tx;
      if (tx_abort) begin
        tx_abort = 1'b0;
      end else begin
        check("tx_start_bit", mon_st, 0);
        check("tx_stop_bit", mon_sp, 1);
        check("tx_byte_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) check("tx_byte", mon_b, exp_tx.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    if (!stop_bit) begin
      uart_rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] frame [7], input int n);
    for (int i = 0; i < n; i++) send_byte(frame[i], 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_wb.size() != 0 || exp_tx.size() != 0 || dut.state != IDLE) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, n < budget, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uart_tx"}, uart_tx, 1);
    check({tag, "_cyc_stb_we"}, {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check({tag, "_adr"}, wb_adr_o, 0);
    check({tag, "_dat"}, wb_dat_o, 0);
    check({tag, "_state"}, dut.state, IDLE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    uart_rx  = 1'b1;
    start_rx = 1'b1;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Basic write
    exp_wb.push_back('{we: 1'b1, adr: 16'h0010, dat: 32'hDEADBEEF});
    send_frame('{8'hAA, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 7);
    wait_done("write_done", 2000);
    check("write_idle_bus", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);

    // Basic read: write data stays on wb_dat_o, reply EF BE AD DE
    rd_value = 32'hDEADBEEF;
    exp_wb.push_back('{we: 1'b0, adr: 16'h0010, dat: 32'hDEADBEEF});
    exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hAD); exp_tx.push_back(8'hDE);
    send_frame('{8'h01, 8'h10, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    wait_done("read_done", 2000);

    // Delayed ack: 20 clocks of wait with outputs held
    ack_delay = 20;
    exp_wb.push_back('{we: 1'b1, adr: 16'h0020, dat: 32'h11223344});
    send_frame('{8'hAA, 8'h20, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, 7);
    wait_done("delayed_write_done", 2000);
    ack_delay = 0;

    // Junk command byte
    send_byte(8'h55, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("junk_state", dut.state, IDLE);

    // Framing error on a command byte
    send_byte(8'hAA, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("framing_state", dut.state, IDLE);

    // Write after junk/framing still executes
    exp_wb.push_back('{we: 1'b1, adr: 16'h1234, dat: 32'hCAFEF00D});
    send_frame('{8'hAA, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA}, 7);
    wait_done("post_junk_write_done", 2000);

    // Receiver disabled: whole frame ignored, then resent with receiver enabled
    start_rx = 1'b0;
    send_frame('{8'hAA, 8'h56, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 7);
    repeat (10) @(posedge clk);
    #1;
    check("rx_disabled_state", dut.state, IDLE);
    check("rx_disabled_adr_held", wb_adr_o, 16'h1234);
    start_rx = 1'b1;
    exp_wb.push_back('{we: 1'b1, adr: 16'h0056, dat: 32'h12345678});
    send_frame('{8'hAA, 8'h56, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 7);
    wait_done("rx_enabled_write_done", 2000);

    // Reset while collecting data bytes
    send_frame('{8'hAA, 8'h10, 8'h00, 8'hEF, 8'h0, 8'h0, 8'h0}, 4);
    check("mid_rx_data_state", dut.state, RX_DATA);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_rx_data");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_wb.push_back('{we: 1'b1, adr: 16'h00A5, dat: 32'h0BADF00D});
    send_frame('{8'hAA, 8'hA5, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B}, 7);
    wait_done("post_reset_write_done", 2000);

    // Reset while replying
    rd_value = 32'h12345678;
    tx_abort = 1'b1;
    exp_wb.push_back('{we: 1'b0, adr: 16'h0021, dat: 32'h0BADF00D});
    send_frame('{8'h01, 8'h21, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    n = 0;
    while (dut.state != TX_DATA && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("reach_tx_data", n < 500, 1);
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_tx_data");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("rst_tx_scoreboard_empty", exp_wb.size() + exp_tx.size(), 0);
    check("rst_tx_line_idle", uart_tx, 1);

    // Recovery read with a different pattern
    rd_value = 32'hA5C30F81;
    exp_wb.push_back('{we: 1'b0, adr: 16'h0030, dat: 32'h0});
    exp_tx.push_back(8'h81); exp_tx.push_back(8'h0F);
    exp_tx.push_back(8'hC3); exp_tx.push_back(8'hA5);
    send_frame('{8'h01, 8'h30, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
    wait_done("recovery_read_done", 2000);
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("final_uart_idle", uart_tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
